multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//   Multicycle MIPS control unit: the initiator side of the 32-bit ALU's alucontrol/zero interface.
//   Decodes op/funct, sequences FETCH..WRITEBACK through a Moore FSM and drives the ALU operand
//   selects, alucontrol, datapath mux selects and write strobes. Samples ALU zero for BEQ.
//   Sits beside the datapath; one instruction completes every 3-5 states, plus memory wait cycles.
// PARAMETERS
//   none (ISA subset fixed: LW, SW, R-type ADD/SUB/AND/OR/SLT, BEQ, ADDI, J)
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   op          in   6  instr[31:26], valid from DECODE onward
//   funct       in   6  instr[5:0]
//   zero        in   1  ALU zero flag (aluout == 0)
//   mem_ready   in   1  memory done; completes FETCH/MEMREAD/MEMWRITE
//   alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   alusrca     out  1  0=PC, 1=A reg
//   alusrcb     out  2  00=B, 01=const 4, 10=signimm, 11=signimm<<2
//   pcsrc       out  2  00=aluresult, 01=aluout reg, 10=jump target
//   iord, regdst, memtoreg  out 1 each  datapath mux selects
//   irwrite, memwrite, regwrite, pcen  out 1 each  write strobes
//   illegal_op  out  1  one-cycle pulse in DECODE on unsupported op or R-type funct
// BEHAVIOUR
//   - State register resets asynchronously to FETCH. All strobes (irwrite, memwrite, regwrite,
//     pcen, illegal_op) are 0 while rst_n=0. Other outputs show FETCH values.
//     Reset mid-instruction abandons it; no partial write may issue after rst_n rises.
//   - Outputs are Moore decodes of state. alucontrol is a combinational function of aluop/funct.
//     pcen = pcwrite | (branch & zero).
//   - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
//     aluop 10 -> funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111;
//     any other funct -> 010 and flags illegal.
//   - State table, listing outputs that are not default and the next state
//     (defaults: all strobes 0, selects 0, aluop 00):
//     FETCH:   alusrcb=01; irwrite=pcwrite=mem_ready. Holds until mem_ready=1, then goes to DECODE.
//     DECODE:  alusrcb=11. Next state by op:
//              100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX;
//              000010 -> JUMP; else (or bad funct) -> FETCH with illegal_op=1.
//     MEMADR:  alusrca=1, alusrcb=10. LW -> MEMREAD; SW -> MEMWRITE.
//     MEMREAD: iord=1. Holds until mem_ready, then MEMWB.
//     MEMWB:   memtoreg=1, regwrite=1 -> FETCH.
//     MEMWRITE: iord=1, memwrite=1. Holds until mem_ready, then FETCH.
//              memwrite stays high every wait cycle.
//     EXECUTE: alusrca=1, aluop=10 -> ALUWB.
//     ALUWB:   regdst=1, regwrite=1 -> FETCH.
//     BRANCH:  alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
//     ADDIEX:  alusrca=1, alusrcb=10 -> ADDIWB.
//     ADDIWB:  regwrite=1 -> FETCH.
//     JUMP:    pcsrc=10, pcwrite=1 -> FETCH.
//   - Latency with no memory wait:
//     LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
//   - The FSM never reaches an unreachable encoding. If it does, the next state is FETCH.
// STRUCTURE
//   - Package mips_ctrl_pkg holds:
//     state_t enum; opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
//     funct constants; alucontrol constants ALU_AND..ALU_SLT; aluop_t.
//   - Sub-module alu_decoder (combinational): aluop + funct -> alucontrol, funct_illegal.
//   - Top holds the state register, next-state logic, output decode and pcen.
// TESTING
//   1. Reset: rst_n=0 mid-EXECUTE, then release with mem_ready=1.
//      -> state FETCH; strobes stay 0 during reset; irwrite=pcen=1 on first cycle after release.
//   2. op=100011, mem_ready always 1.
//      -> FETCH, DECODE, MEMADR(alusrcb=10), MEMREAD(iord=1), MEMWB(regwrite=1, memtoreg=1); 5 cycles.
//   3. op=000000 for each of funct 100000/100010/100100/100101/101010.
//      -> in EXECUTE, alucontrol = 010/110/000/001/111; regwrite=1, regdst=1 in ALUWB.
//   4. op=000100: zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0.
//   5. op=101011 with mem_ready=0 for 3 cycles in MEMWRITE.
//      -> memwrite=1 for 4 cycles, then FETCH. FETCH with mem_ready=0 holds irwrite=0.
//   6. op=111111 or R-type funct=000111.
//      -> illegal_op=1 for exactly one DECODE cycle; regwrite, memwrite, pcen all 0; back to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Contents: FSM states, ALU op classes, opcode/funct and alucontrol codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTE,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: aluop + funct -> alucontrol; flags unsupported funct.
// Ports: i_aluop, i_funct in; o_alucontrol, o_funct_illegal out.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucontrol,
   output logic       o_funct_illegal
);

   logic [2:0] w_fctrl;

   // funct legality is independent of aluop so DECODE can flag it early
   always_comb begin
      w_fctrl         = ALU_ADD;
      o_funct_illegal = 1'b0;
      case (i_funct)
         F_ADD:   w_fctrl = ALU_ADD;
         F_SUB:   w_fctrl = ALU_SUB;
         F_AND:   w_fctrl = ALU_AND;
         F_OR:    w_fctrl = ALU_OR;
         F_SLT:   w_fctrl = ALU_SLT;
         default: o_funct_illegal = 1'b1;
      endcase
   end

   always_comb begin
      o_alucontrol = ALU_ADD;
      case (i_aluop)
         ALUOP_SUB:   o_alucontrol = ALU_SUB;
         ALUOP_FUNCT: o_alucontrol = w_fctrl;
         default:     o_alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences FETCH..WRITEBACK, drives datapath.
// Ports: clk, rst_n, op, funct, zero, mem_ready in; selects/strobes out.
module multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] alucontrol,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       illegal_op
);

   state_t     r_state;
   state_t     w_next;
   aluop_t     w_aluop;
   logic       w_funct_ill;
   logic       w_illegal;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_irwrite;
   logic       w_memwrite;
   logic       w_regwrite;
   logic       w_illegal_op;

   alu_decoder u_alu_dec (
      .i_aluop         (w_aluop),
      .i_funct         (funct),
      .o_alucontrol    (alucontrol),
      .o_funct_illegal (w_funct_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_illegal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_BEQ,
         OP_ADDI, OP_J:  w_illegal = 1'b0;
         OP_RTYPE:       w_illegal = w_funct_ill;
         default:        w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_next       = S_FETCH;
      w_aluop      = ALUOP_ADD;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      iord         = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      w_irwrite    = 1'b0;
      w_memwrite   = 1'b0;
      w_regwrite   = 1'b0;
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      w_illegal_op = 1'b0;
      case (r_state)
         S_FETCH: begin
            alusrcb   = 2'b01;
            w_irwrite = mem_ready;
            w_pcwrite = mem_ready;
            w_next    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            if (w_illegal) begin
               w_illegal_op = 1'b1;
               w_next       = S_FETCH;
            end else begin
               case (op)
                  OP_LW, OP_SW: w_next = S_MEMADR;
                  OP_RTYPE:     w_next = S_EXECUTE;
                  OP_BEQ:       w_next = S_BRANCH;
                  OP_ADDI:      w_next = S_ADDIEX;
                  OP_J:         w_next = S_JUMP;
                  default:      w_next = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            iord   = 1'b1;
            w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            iord       = 1'b1;
            w_memwrite = 1'b1;
            w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            w_aluop = ALUOP_FUNCT;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            w_regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            w_aluop  = ALUOP_SUB;
            pcsrc    = 2'b01;
            w_branch = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
         end
         S_JUMP: begin
            pcsrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // strobes are forced low while reset is held, even though FETCH is shown
   assign irwrite    = w_irwrite & rst_n;
   assign memwrite   = w_memwrite & rst_n;
   assign regwrite   = w_regwrite & rst_n;
   assign illegal_op = w_illegal_op & rst_n;
   assign pcen       = (w_pcwrite | (w_branch & zero)) & rst_n;

endmodule
